// File: rtl/keypad_clock.sv
// Free-running divider for the keypad scanner: produces a 50%-duty square wave
// `tick` plus a one-clk strobe marking each rising edge of `tick`.
module keypad_clock #(
  parameter int CLK_FREQ_HZ  = 50000000,
  parameter int TICK_FREQ_HZ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic tick_stb
);

  // The zero guard only keeps elaboration alive long enough to report a bad TICK_FREQ_HZ.
  localparam int HALF_RAW   = (TICK_FREQ_HZ == 0) ? 1 : CLK_FREQ_HZ / (2 * TICK_FREQ_HZ);
  localparam int HALF_COUNT = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CNT_W      = (HALF_COUNT <= 2) ? 1 : $clog2(HALF_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_COUNT - 1);

  if (TICK_FREQ_HZ <= 0 || TICK_FREQ_HZ > CLK_FREQ_HZ / 2) begin : g_bad_param
    $error("keypad_clock: TICK_FREQ_HZ must be in 1..CLK_FREQ_HZ/2");
  end

  logic [CNT_W-1:0] cnt;

  // Wrap is an explicit compare, so a non-power-of-two HALF_COUNT never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      tick     <= 1'b0;
      tick_stb <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt      <= '0;
      tick     <= ~tick;
      tick_stb <= ~tick;
    end else begin
      cnt      <= cnt + CNT_W'(1);
      tick_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_clock.sv
// Directed bench for keypad_clock: four parameterisations on one clock, with
// expected tick/tick_stb values derived from edge counts since reset release.
module tb_keypad_clock;

  logic clk = 1'b0;
  logic rst_n;
  logic rst5_n;
  logic tick5, stb5, tick1, stb1, tick3, stb3, tickd, stbd;

  always #5 clk = ~clk;

  keypad_clock #(.CLK_FREQ_HZ(100), .TICK_FREQ_HZ(10)) u_hc5 (
    .clk(clk), .rst_n(rst5_n), .tick(tick5), .tick_stb(stb5));
  keypad_clock #(.CLK_FREQ_HZ(4), .TICK_FREQ_HZ(2)) u_hc1 (
    .clk(clk), .rst_n(rst_n), .tick(tick1), .tick_stb(stb1));
  keypad_clock #(.CLK_FREQ_HZ(100), .TICK_FREQ_HZ(15)) u_hc3 (
    .clk(clk), .rst_n(rst_n), .tick(tick3), .tick_stb(stb3));
  keypad_clock u_def (
    .clk(clk), .rst_n(rst_n), .tick(tickd), .tick_stb(stbd));

  typedef struct {
    int         id;
    string      tag;
    logic [1:0] exp;
  } sb_t;

  sb_t q[$];
  int  total  = 0;
  int  passed = 0;
  int  n5 = 0, n1 = 0, n3 = 0, nd = 0;
  bit  rel5 = 1'b0, rel = 1'b0;
  int  rises5 = 0;
  logic prev5 = 1'b0;

  // After edge n of a free run with half-period h: tick is the parity of n/h,
  // and the strobe fires exactly on edges where tick has just risen.
  function automatic logic [1:0] expv(int n, int h);
    int ph;
    ph = n / h;
    return {ph[0], (n % h == 0) && ph[0] && (n > 0)};
  endfunction

  function automatic logic [1:0] obs(int id);
    case (id)
      0:       return {tick5, stb5};
      1:       return {tick1, stb1};
      2:       return {tick3, stb3};
      default: return {tickd, stbd};
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic push(int id, string tag, logic [1:0] e);
    sb_t s;
    s.id = id; s.tag = tag; s.exp = e;
    q.push_back(s);
  endtask

  task automatic drain();
    sb_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      chk(s.tag, {30'd0, obs(s.id)}, {30'd0, s.exp});
    end
  endtask

  // One clk edge: advance edge counts, queue expectations, then compare.
  task automatic step();
    @(posedge clk);
    #1;
    if (rel5) n5++;
    if (rel) begin
      n1++; n3++; nd++;
    end
    push(0, $sformatf("hc5 e%0d", n5), rel5 ? expv(n5, 5) : 2'b00);
    push(1, $sformatf("hc1 e%0d", n1), expv(n1, 1));
    push(2, $sformatf("hc3 e%0d", n3), expv(n3, 3));
    if (nd == 24999 || nd == 25000 || nd == 25001 || nd == 49999 || nd == 50000)
      push(3, $sformatf("def e%0d", nd), expv(nd, 25000));
    drain();
    if (rel5 && !prev5 && tick5) rises5++;
    prev5 = tick5;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst5_n = 1'b0;
    #2;
    push(0, "hc5 reset", 2'b00);
    push(1, "hc1 reset", 2'b00);
    push(2, "hc3 reset", 2'b00);
    push(3, "def reset", 2'b00);
    drain();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    rst5_n = 1'b1;
    rel    = 1'b1;
    rel5   = 1'b1;

    while (n5 < 1000) step();
    chk("hc5 rises in 1000 cycles", rises5, 100);

    // Land on count 3 of a high phase, then yank reset between edges.
    while (n5 % 10 != 8) step();
    chk("hc5 high before async reset", {31'd0, tick5}, 1);
    #2;
    rst5_n = 1'b0;
    rel5   = 1'b0;
    #1;
    push(0, "hc5 async reset", 2'b00);
    drain();
    step();
    step();
    #3;
    rst5_n = 1'b1;
    rel5   = 1'b1;
    n5     = 0;
    prev5  = 1'b0;
    rises5 = 0;
    while (n5 < 20) step();
    chk("hc5 rises after reset", rises5, 2);

    while (nd < 50000) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
